// File: rtl/fight_pkg.sv
// Shared state encodings, default tuning constants and the saturating health subtract.
// Purely combinational helpers; no state lives here.
package fight_pkg;

    typedef enum logic [1:0] {
        GS_START = 2'd0,
        GS_FIGHT = 2'd1,
        GS_KO    = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        AS_IDLE    = 2'd0,
        AS_ACTIVE  = 2'd1,
        AS_RECOVER = 2'd2
    } atk_state_t;

    typedef enum logic {
        AK_PUNCH = 1'b0,
        AK_KICK  = 1'b1
    } atk_kind_t;

    localparam int HP_W  = 7;
    localparam int POS_W = 10;

    localparam int HP_MAX_DEF      = 100;
    localparam int PUNCH_DMG_DEF   = 5;
    localparam int KICK_DMG_DEF    = 10;
    localparam int PUNCH_REACH_DEF = 20;
    localparam int KICK_REACH_DEF  = 40;
    localparam int ACTIVE_FR_DEF   = 4;
    localparam int RECOVER_FR_DEF  = 12;
    localparam int KO_HOLD_DEF     = 180;

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                                 input logic [HP_W-1:0] dmg);
        return (hp > dmg) ? hp - dmg : '0;
    endfunction

endpackage

// File: rtl/attack_seq.sv
// Per-player attack sequencer: IDLE -> ACTIVE (ACTIVE_FR frames) -> RECOVER (RECOVER_FR frames).
// o_eval is high only on the first ACTIVE frame; dropping i_en forces IDLE on the next edge.
module attack_seq
    import fight_pkg::*;
#(
    parameter int ACTIVE_FR  = ACTIVE_FR_DEF,
    parameter int RECOVER_FR = RECOVER_FR_DEF
) (
    input  logic      frame_clk,
    input  logic      Reset,
    input  logic      i_en,
    input  logic      i_punch,
    input  logic      i_kick,
    input  logic      i_block,
    output logic      o_busy,
    output logic      o_eval,
    output atk_kind_t o_kind
);

    localparam int CNT_MAX = (ACTIVE_FR > RECOVER_FR) ? ACTIVE_FR : RECOVER_FR;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(ACTIVE_FR - 1);
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVER_FR - 1);

    atk_state_t       r_state;
    atk_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    atk_kind_t        r_kind;
    atk_kind_t        w_kind_nxt;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state <= AS_IDLE;
            r_cnt   <= '0;
            r_kind  <= AK_PUNCH;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_kind  <= w_kind_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_kind_nxt  = r_kind;
        if (!i_en) begin
            w_state_nxt = AS_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                AS_IDLE: begin
                    // Kick wins over punch; holding block suppresses any new attack.
                    if (!i_block && (i_kick || i_punch)) begin
                        w_state_nxt = AS_ACTIVE;
                        w_cnt_nxt   = ACT_LOAD;
                        w_kind_nxt  = i_kick ? AK_KICK : AK_PUNCH;
                    end
                end
                AS_ACTIVE: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = AS_RECOVER;
                        w_cnt_nxt   = REC_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                AS_RECOVER: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = AS_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = AS_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_busy = (r_state != AS_IDLE);
    assign o_eval = (r_state == AS_ACTIVE) && (r_cnt == ACT_LOAD);
    assign o_kind = r_kind;

endmodule

// File: rtl/fight_ctrl.sv
// Round controller: START/FIGHT/KO game FSM, two attack sequencers and hit/damage arbitration.
// Hits are judged on an attacker's first ACTIVE frame; hp and hit pulses update on the following edge.
module fight_ctrl
    import fight_pkg::*;
#(
    parameter int HP_MAX      = HP_MAX_DEF,
    parameter int PUNCH_DMG   = PUNCH_DMG_DEF,
    parameter int KICK_DMG    = KICK_DMG_DEF,
    parameter int PUNCH_REACH = PUNCH_REACH_DEF,
    parameter int KICK_REACH  = KICK_REACH_DEF,
    parameter int ACTIVE_FR   = ACTIVE_FR_DEF,
    parameter int RECOVER_FR  = RECOVER_FR_DEF,
    parameter int KO_HOLD     = KO_HOLD_DEF
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             start_key,
    input  logic             punch1,
    input  logic             kick1,
    input  logic             block1,
    input  logic             punch2,
    input  logic             kick2,
    input  logic             block2,
    input  logic [POS_W-1:0] p1_right_edge,
    input  logic [POS_W-1:0] p2_left_edge,
    output logic             startscreen,
    output logic             deathL,
    output logic             deathR,
    output logic [HP_W-1:0]  hp1,
    output logic [HP_W-1:0]  hp2,
    output logic             atk1_busy,
    output logic             atk2_busy,
    output logic             hit1,
    output logic             hit2
);

    localparam int KO_W = $clog2(KO_HOLD + 1);
    localparam logic [KO_W-1:0]  KO_LOAD  = KO_W'(KO_HOLD - 1);
    localparam logic [HP_W-1:0]  HP_INIT  = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0]  P_DMG    = HP_W'(PUNCH_DMG);
    localparam logic [HP_W-1:0]  K_DMG    = HP_W'(KICK_DMG);
    localparam logic [POS_W-1:0] P_REACH  = POS_W'(PUNCH_REACH);
    localparam logic [POS_W-1:0] K_REACH  = POS_W'(KICK_REACH);

    game_state_t     r_state;
    game_state_t     w_state_nxt;
    logic [KO_W-1:0] r_ko_cnt;
    logic [KO_W-1:0] w_ko_nxt;
    logic [HP_W-1:0] r_hp1;
    logic [HP_W-1:0] r_hp2;
    logic [HP_W-1:0] w_hp1_nxt;
    logic [HP_W-1:0] w_hp2_nxt;
    logic            r_hit1;
    logic            r_hit2;
    logic            w_hit1_nxt;
    logic            w_hit2_nxt;
    logic            r_key_d;

    logic            w_fight;
    logic            w_eval1;
    logic            w_eval2;
    atk_kind_t       w_kind1;
    atk_kind_t       w_kind2;
    logic [POS_W-1:0] w_gap;
    logic [POS_W-1:0] w_reach1;
    logic [POS_W-1:0] w_reach2;
    logic [HP_W-1:0] w_base1;
    logic [HP_W-1:0] w_base2;
    logic [HP_W-1:0] w_dmg_to2;
    logic [HP_W-1:0] w_dmg_to1;
    logic            w_land_on2;
    logic            w_land_on1;

    assign w_fight = (r_state == GS_FIGHT);

    attack_seq #(
        .ACTIVE_FR  (ACTIVE_FR),
        .RECOVER_FR (RECOVER_FR)
    ) u_seq1 (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .i_en      (w_fight),
        .i_punch   (punch1),
        .i_kick    (kick1),
        .i_block   (block1),
        .o_busy    (atk1_busy),
        .o_eval    (w_eval1),
        .o_kind    (w_kind1)
    );

    attack_seq #(
        .ACTIVE_FR  (ACTIVE_FR),
        .RECOVER_FR (RECOVER_FR)
    ) u_seq2 (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .i_en      (w_fight),
        .i_punch   (punch2),
        .i_kick    (kick2),
        .i_block   (block2),
        .o_busy    (atk2_busy),
        .o_eval    (w_eval2),
        .o_kind    (w_kind2)
    );

    // Overlapping fighters count as zero distance rather than wrapping.
    assign w_gap = (p2_left_edge <= p1_right_edge) ? '0 : (p2_left_edge - p1_right_edge);

    assign w_reach1 = (w_kind1 == AK_KICK) ? K_REACH : P_REACH;
    assign w_reach2 = (w_kind2 == AK_KICK) ? K_REACH : P_REACH;
    assign w_base1  = (w_kind1 == AK_KICK) ? K_DMG : P_DMG;
    assign w_base2  = (w_kind2 == AK_KICK) ? K_DMG : P_DMG;

    assign w_dmg_to2 = block2 ? (w_base1 >> 2) : w_base1;
    assign w_dmg_to1 = block1 ? (w_base2 >> 2) : w_base2;

    assign w_land_on2 = w_eval1 && (w_gap <= w_reach1);
    assign w_land_on1 = w_eval2 && (w_gap <= w_reach2);

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state  <= GS_START;
            r_ko_cnt <= '0;
            r_hp1    <= HP_INIT;
            r_hp2    <= HP_INIT;
            r_hit1   <= 1'b0;
            r_hit2   <= 1'b0;
            r_key_d  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_ko_cnt <= w_ko_nxt;
            r_hp1    <= w_hp1_nxt;
            r_hp2    <= w_hp2_nxt;
            r_hit1   <= w_hit1_nxt;
            r_hit2   <= w_hit2_nxt;
            r_key_d  <= start_key;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ko_nxt    = r_ko_cnt;
        w_hp1_nxt   = r_hp1;
        w_hp2_nxt   = r_hp2;
        w_hit1_nxt  = 1'b0;
        w_hit2_nxt  = 1'b0;
        case (r_state)
            GS_START: begin
                // Key held high across a KO must be released before a new round.
                if (start_key && !r_key_d) begin
                    w_state_nxt = GS_FIGHT;
                    w_hp1_nxt   = HP_INIT;
                    w_hp2_nxt   = HP_INIT;
                end
            end
            GS_FIGHT: begin
                if (w_land_on2) begin
                    w_hp2_nxt  = sat_sub(r_hp2, w_dmg_to2);
                    w_hit2_nxt = 1'b1;
                end
                if (w_land_on1) begin
                    w_hp1_nxt  = sat_sub(r_hp1, w_dmg_to1);
                    w_hit1_nxt = 1'b1;
                end
                if ((r_hp1 == '0) || (r_hp2 == '0)) begin
                    w_state_nxt = GS_KO;
                    w_ko_nxt    = KO_LOAD;
                end
            end
            GS_KO: begin
                if (r_ko_cnt == '0) begin
                    w_state_nxt = GS_START;
                end else begin
                    w_ko_nxt = r_ko_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = GS_START;
                w_ko_nxt    = '0;
            end
        endcase
    end

    assign startscreen = (r_state == GS_START);
    assign deathL      = (r_hp1 == '0);
    assign deathR      = (r_hp2 == '0);
    assign hp1         = r_hp1;
    assign hp2         = r_hp2;
    assign hit1        = r_hit1;
    assign hit2        = r_hit2;

endmodule

// File: tb/tb_fight_ctrl.sv
// Bench for fight_ctrl: directed table, hand-written KO round, then random play against a frame-level model.
module tb_fight_ctrl;

    localparam int HP = 100, PD = 5, KD = 10, PR = 20, KR = 40;
    localparam int AF = 4, RF = 12, KH = 180;

    logic       frame_clk = 1'b0;
    logic       Reset, start_key;
    logic       punch1, kick1, block1, punch2, kick2, block2;
    logic [9:0] p1_right_edge, p2_left_edge;
    logic       startscreen, deathL, deathR;
    logic [6:0] hp1, hp2;
    logic       atk1_busy, atk2_busy, hit1, hit2;

    always #5 frame_clk = ~frame_clk;

    fight_ctrl #(
        .HP_MAX(HP), .PUNCH_DMG(PD), .KICK_DMG(KD), .PUNCH_REACH(PR), .KICK_REACH(KR),
        .ACTIVE_FR(AF), .RECOVER_FR(RF), .KO_HOLD(KH)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .start_key(start_key),
        .punch1(punch1), .kick1(kick1), .block1(block1),
        .punch2(punch2), .kick2(kick2), .block2(block2),
        .p1_right_edge(p1_right_edge), .p2_left_edge(p2_left_edge),
        .startscreen(startscreen), .deathL(deathL), .deathR(deathR),
        .hp1(hp1), .hp2(hp2), .atk1_busy(atk1_busy), .atk2_busy(atk2_busy),
        .hit1(hit1), .hit2(hit2)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phase 0=start 1=fight 2=ko; age = frames since attack began, -1 when idle.
    int m_phase, m_ko_left, m_hp1, m_hp2, m_hit1, m_hit2;
    int m_age1, m_age2, m_kind1, m_kind2, m_prev;

    function automatic int reach_of(int kind);
        return kind ? KR : PR;
    endfunction

    function automatic int dmg_of(int kind, bit blk);
        int d;
        d = kind ? KD : PD;
        return blk ? d / 4 : d;
    endfunction

    function automatic int next_age(int age, bit fight, bit blk, bit req);
        if (!fight) return -1;
        if (age >= 0) return (age + 1 >= AF + RF) ? -1 : age + 1;
        return (req && !blk) ? 0 : -1;
    endfunction

    task automatic model_edge();
        int  gap, d, nhp1, nhp2, na1, na2;
        bit  fight;
        if (Reset) begin
            m_phase = 0; m_ko_left = 0; m_hp1 = HP; m_hp2 = HP; m_hit1 = 0; m_hit2 = 0;
            m_age1 = -1; m_age2 = -1; m_kind1 = 0; m_kind2 = 0; m_prev = 1;
        end else begin
            fight = (m_phase == 1);
            gap = (int'(p2_left_edge) > int'(p1_right_edge)) ?
                  int'(p2_left_edge) - int'(p1_right_edge) : 0;
            nhp1 = m_hp1; nhp2 = m_hp2; m_hit1 = 0; m_hit2 = 0;
            if (fight && m_age1 == 0 && gap <= reach_of(m_kind1)) begin
                d = dmg_of(m_kind1, block2);
                nhp2 = (m_hp2 > d) ? m_hp2 - d : 0;
                m_hit2 = 1;
            end
            if (fight && m_age2 == 0 && gap <= reach_of(m_kind2)) begin
                d = dmg_of(m_kind2, block1);
                nhp1 = (m_hp1 > d) ? m_hp1 - d : 0;
                m_hit1 = 1;
            end
            na1 = next_age(m_age1, fight, block1, punch1 | kick1);
            na2 = next_age(m_age2, fight, block2, punch2 | kick2);
            if (m_age1 < 0 && na1 == 0) m_kind1 = kick1 ? 1 : 0;
            if (m_age2 < 0 && na2 == 0) m_kind2 = kick2 ? 1 : 0;
            case (m_phase)
                0: if (start_key && !m_prev) begin
                       m_phase = 1; nhp1 = HP; nhp2 = HP;
                   end
                1: if (m_hp1 == 0 || m_hp2 == 0) begin
                       m_phase = 2; m_ko_left = KH;
                   end
                default: begin
                    m_ko_left = m_ko_left - 1;
                    if (m_ko_left == 0) m_phase = 0;
                end
            endcase
            m_hp1 = nhp1; m_hp2 = nhp2; m_age1 = na1; m_age2 = na2;
            m_prev = start_key;
        end
    endtask

    task automatic check_model();
        n_vec++;
        if (startscreen !== (m_phase == 0) || int'(hp1) != m_hp1 || int'(hp2) != m_hp2 ||
            deathL !== (m_hp1 == 0) || deathR !== (m_hp2 == 0) ||
            atk1_busy !== (m_age1 >= 0) || atk2_busy !== (m_age2 >= 0) ||
            hit1 !== m_hit1[0] || hit2 !== m_hit2[0]) begin
            n_bad++;
            $display("FAIL model t=%0t: dut ss=%0d hp=%0d/%0d dL/R=%0d%0d busy=%0d%0d hit=%0d%0d; need ss=%0d hp=%0d/%0d busy=%0d%0d hit=%0d%0d",
                     $time, startscreen, hp1, hp2, deathL, deathR, atk1_busy, atk2_busy, hit1, hit2,
                     m_phase == 0, m_hp1, m_hp2, m_age1 >= 0, m_age2 >= 0, m_hit1, m_hit2);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic check_field(string name, int got, int exp);
        if (exp >= 0) begin
            n_vec++;
            if (got != exp) begin
                n_bad++;
                $display("FAIL %s: got %0d required %0d", name, got, exp);
            end
        end
    endtask

    typedef struct {
        int n, rst, key, p1, k1, b1, p2, k2, b2, e1, e2;
        int x_ss, x_hp1, x_hp2, x_hit1, x_hit2, x_bz1, x_bz2, x_dl, x_dr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(int n, int rst, int key, int p1, int k1, int b1, int p2, int k2,
                                 int b2, int e1, int e2, int ss, int h1, int h2, int t1, int t2,
                                 int z1, int z2, int dl, int dr);
        vec_t v;
        v.n = n; v.rst = rst; v.key = key; v.p1 = p1; v.k1 = k1; v.b1 = b1;
        v.p2 = p2; v.k2 = k2; v.b2 = b2; v.e1 = e1; v.e2 = e2;
        v.x_ss = ss; v.x_hp1 = h1; v.x_hp2 = h2; v.x_hit1 = t1; v.x_hit2 = t2;
        v.x_bz1 = z1; v.x_bz2 = z2; v.x_dl = dl; v.x_dr = dr;
        return v;
    endfunction

    task automatic drive_idle();
        punch1 = 0; kick1 = 0; block1 = 0; punch2 = 0; kick2 = 0; block2 = 0;
    endtask

    localparam int X = -1;

    initial begin
        Reset = 1; start_key = 0; drive_idle();
        p1_right_edge = 10'd300; p2_left_edge = 10'd315;

        //              n rs ky p1 k1 b1 p2 k2 b2  e1  e2   ss  hp1  hp2 ht1 ht2 bz1 bz2 dL dR
        tbl.push_back(row( 2,1,0, 0,0,0, 0,0,0, 300,315,  1, 100, 100,  0,  0,  0,  0, 0, 0));
        tbl.push_back(row( 1,0,0, 0,0,0, 0,0,0, 300,315,  1,   X,   X,  X,  X,  X,  X, X, X));
        tbl.push_back(row( 1,0,1, 0,0,0, 0,0,0, 300,315,  0, 100, 100,  0,  0,  0,  0, 0, 0));
        tbl.push_back(row( 1,0,1, 1,0,0, 0,0,0, 300,315,  X, 100, 100,  X,  0,  1,  0, X, X));
        tbl.push_back(row( 1,0,1, 0,0,0, 0,0,0, 300,315,  X,   X,  95,  X,  1,  1,  X, X, X));
        tbl.push_back(row( 1,0,1, 0,0,0, 0,0,0, 300,315,  X,   X,  95,  X,  0,  1,  X, X, X));
        tbl.push_back(row(13,0,1, 0,0,0, 0,0,0, 300,315,  X,   X,   X,  X,  X,  1,  X, X, X));
        tbl.push_back(row( 1,0,1, 0,0,0, 0,0,0, 300,315,  X,   X,  95,  X,  X,  0,  X, X, X));
        tbl.push_back(row( 1,0,1, 1,0,0, 0,0,0, 300,315,  X,   X,  95,  X,  X,  1,  X, X, X));
        tbl.push_back(row( 1,0,1, 1,0,0, 0,0,0, 300,315,  X,   X,  90,  X,  1,  1,  X, X, X));
        tbl.push_back(row(14,0,1, 1,0,0, 0,0,0, 300,315,  X,   X,  90,  X,  0,  1,  X, X, X));
        tbl.push_back(row( 1,0,1, 1,0,0, 0,0,0, 300,315,  X,   X,  90,  X,  X,  0,  X, X, X));
        tbl.push_back(row( 1,0,1, 1,0,0, 0,0,0, 300,315,  X,   X,   X,  X,  X,  1,  X, X, X));
        tbl.push_back(row( 1,0,1, 0,0,0, 0,0,0, 300,315,  X,   X,  85,  X,  1,  X,  X, X, X));
        tbl.push_back(row(16,0,1, 0,0,0, 0,0,0, 300,315,  X,   X,  85,  X,  X,  0,  X, X, X));
        tbl.push_back(row( 1,0,1, 0,1,0, 0,0,0, 300,360,  X,   X,   X,  X,  X,  1,  X, X, X));
        tbl.push_back(row( 1,0,1, 0,0,0, 0,0,0, 300,360,  X,   X,  85,  X,  0,  X,  X, X, X));
        tbl.push_back(row(16,0,1, 0,0,0, 0,0,0, 300,360,  X,   X,   X,  X,  X,  0,  X, X, X));
        tbl.push_back(row( 1,0,1, 0,1,0, 0,0,1, 300,330,  X,   X,   X,  X,  X,  1,  0, X, X));
        tbl.push_back(row( 1,0,1, 0,0,0, 0,0,1, 300,330,  X,   X,  83,  X,  1,  X,  X, X, X));
        tbl.push_back(row(16,0,1, 0,0,0, 0,0,0, 300,330,  X,   X,  83,  X,  X,  0,  X, X, X));
        tbl.push_back(row( 1,0,1, 1,0,0, 0,1,0, 300,310,  X,   X,   X,  X,  X,  1,  1, X, X));
        tbl.push_back(row( 1,0,1, 0,0,0, 0,0,0, 300,310,  0,  90,  78,  1,  1,  X,  X, 0, 0));
        tbl.push_back(row(17,0,1, 0,0,0, 0,0,0, 300,310,  X,  90,  78,  0,  0,  0,  0, X, X));
        tbl.push_back(row( 1,0,1, 1,0,0, 0,0,0, 300,320,  X,   X,   X,  X,  X,  1,  X, X, X));
        tbl.push_back(row( 1,0,1, 0,0,0, 0,0,0, 300,320,  X,   X,  73,  X,  1,  X,  X, X, X));
        tbl.push_back(row(16,0,1, 0,0,0, 0,0,0, 300,320,  X,   X,   X,  X,  X,  0,  X, X, X));
        tbl.push_back(row( 1,0,1, 1,0,0, 0,0,0, 300,321,  X,   X,   X,  X,  X,  1,  X, X, X));
        tbl.push_back(row( 1,0,1, 0,0,0, 0,0,0, 300,321,  X,   X,  73,  X,  0,  X,  X, X, X));
        tbl.push_back(row(16,0,1, 0,0,0, 0,0,0, 300,321,  X,   X,   X,  X,  X,  0,  X, X, X));
        tbl.push_back(row( 1,0,1, 0,0,0, 0,1,0, 300,290,  X,   X,   X,  X,  X,  X,  1, X, X));
        tbl.push_back(row( 1,0,1, 0,0,0, 0,0,0, 300,290,  X,  80,   X,  1,  X,  X,  X, X, X));
        tbl.push_back(row(16,0,1, 0,0,0, 0,0,0, 300,290,  X,   X,   X,  X,  X,  X,  0, X, X));
        tbl.push_back(row( 1,0,1, 1,0,1, 0,0,0, 300,315,  X,   X,   X,  X,  X,  0,  X, X, X));
        tbl.push_back(row( 1,0,1, 1,0,0, 0,0,0, 300,315,  X,   X,   X,  X,  X,  1,  X, X, X));
        tbl.push_back(row( 1,1,1, 0,0,0, 0,0,0, 300,315,  1, 100, 100,  0,  0,  0,  0, 0, 0));

        foreach (tbl[i]) begin
            Reset = tbl[i].rst[0]; start_key = tbl[i].key[0];
            punch1 = tbl[i].p1[0]; kick1 = tbl[i].k1[0]; block1 = tbl[i].b1[0];
            punch2 = tbl[i].p2[0]; kick2 = tbl[i].k2[0]; block2 = tbl[i].b2[0];
            p1_right_edge = 10'(tbl[i].e1); p2_left_edge = 10'(tbl[i].e2);
            repeat (tbl[i].n) tick();
            check_field($sformatf("row%0d.startscreen", i), int'(startscreen), tbl[i].x_ss);
            check_field($sformatf("row%0d.hp1", i), int'(hp1), tbl[i].x_hp1);
            check_field($sformatf("row%0d.hp2", i), int'(hp2), tbl[i].x_hp2);
            check_field($sformatf("row%0d.hit1", i), int'(hit1), tbl[i].x_hit1);
            check_field($sformatf("row%0d.hit2", i), int'(hit2), tbl[i].x_hit2);
            check_field($sformatf("row%0d.atk1_busy", i), int'(atk1_busy), tbl[i].x_bz1);
            check_field($sformatf("row%0d.atk2_busy", i), int'(atk2_busy), tbl[i].x_bz2);
            check_field($sformatf("row%0d.deathL", i), int'(deathL), tbl[i].x_dl);
            check_field($sformatf("row%0d.deathR", i), int'(deathR), tbl[i].x_dr);
        end

        // Knockout round: drain P2 to 5 with punches, finish with a kick, then ride out KO.
        Reset = 0; start_key = 0; drive_idle();
        p1_right_edge = 10'd300; p2_left_edge = 10'd315;
        tick();
        start_key = 1; tick();
        for (int a = 0; a < 19; a++) begin
            punch1 = 1; tick();
            punch1 = 0; repeat (AF + RF) tick();
        end
        check_field("ko.hp2_before", int'(hp2), 5);
        check_field("ko.hp1_before", int'(hp1), 100);
        kick1 = 1; tick();
        kick1 = 0; tick();
        check_field("ko.hp2_zero", int'(hp2), 0);
        check_field("ko.hit2", int'(hit2), 1);
        check_field("ko.deathR", int'(deathR), 1);
        check_field("ko.deathL", int'(deathL), 0);
        check_field("ko.still_fight", int'(startscreen), 0);
        for (int i = 1; i <= KH; i++) begin
            kick2 = (i >= 3 && i <= 6);
            tick();
            if (i == 2) check_field("ko.seq1_forced_idle", int'(atk1_busy), 0);
            if (i == 8) begin
                check_field("ko.kick2_hp1", int'(hp1), 100);
                check_field("ko.kick2_busy", int'(atk2_busy), 0);
            end
        end
        check_field("ko.last_ko_frame", int'(startscreen), 0);
        tick();
        check_field("ko.back_to_start", int'(startscreen), 1);
        check_field("ko.hp2_retained", int'(hp2), 0);
        check_field("ko.deathR_retained", int'(deathR), 1);
        repeat (3) tick();
        check_field("ko.held_key_no_round", int'(startscreen), 1);
        start_key = 0; tick();
        start_key = 1; tick();
        check_field("ko.new_round", int'(startscreen), 0);
        check_field("ko.new_round_hp2", int'(hp2), 100);

        // Random play with occasional resets, every frame compared against the model.
        for (int c = 0; c < 5000; c++) begin
            Reset     = ($urandom_range(0, 599) == 0);
            start_key = ($urandom_range(0, 3) == 0);
            punch1 = ($urandom_range(0, 3) == 0); kick1 = ($urandom_range(0, 4) == 0);
            block1 = ($urandom_range(0, 5) == 0);
            punch2 = ($urandom_range(0, 3) == 0); kick2 = ($urandom_range(0, 4) == 0);
            block2 = ($urandom_range(0, 5) == 0);
            p1_right_edge = 10'(250 + $urandom_range(0, 100));
            p2_left_edge  = 10'(250 + $urandom_range(0, 130));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fight_ctrl.md
FIGHT_CTRL -- requirements
Module: fight_ctrl

Interface
REQ-001 SHALL expose parameter HP_MAX, 100, starting health per player.
REQ-002 SHALL expose parameters PUNCH_DMG, 5 and KICK_DMG, 10, damage per landed hit.
REQ-003 SHALL expose parameters PUNCH_REACH, 20 and KICK_REACH, 40, maximum horizontal gap in pixels for a hit to land.
REQ-004 SHALL expose parameters ACTIVE_FR, 4, RECOVER_FR, 12 and KO_HOLD, 180, frame counts for attack-active, attack-recovery and KO display.
REQ-005 SHALL have port frame_clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port start_key  in  1  level request to begin a round.
REQ-008 SHALL have ports punch1, kick1, block1, punch2, kick2, block2  in  1 each  per-player attack and block requests.
REQ-009 SHALL have ports p1_right_edge, p2_left_edge  in  10 each  unsigned pixel X of the P1 front edge and the P2 front edge.
REQ-010 SHALL have ports startscreen, deathL, deathR  out  1 each  game-phase flags consumed by the fighter motion blocks.
REQ-011 SHALL have ports hp1, hp2  out  7 each  current health.
REQ-012 SHALL have ports atk1_busy, atk2_busy  out  1 each  high while that player's attack sequencer is not IDLE.
REQ-013 SHALL have ports hit1, hit2  out  1 each  one-frame pulse when the hit landed on P1 or P2 respectively.

Function
REQ-014 The game FSM SHALL have states START, FIGHT and KO; startscreen = (state==START).
REQ-015 START->FIGHT SHALL occur on the first frame start_key is sampled high after having been sampled low (rising edge); hp1 and hp2 SHALL load HP_MAX on that transition.
REQ-016 FIGHT->KO SHALL occur on the frame after hp1==0 or hp2==0; deathL = (hp1==0), deathR = (hp2==0), both asserted if both reach 0 on the same frame.
REQ-017 KO SHALL hold exactly KO_HOLD frames via a down-counter, then return to START; hp values SHALL be retained in KO and START until the next round begins.
REQ-018 Each player SHALL have an attack sequencer with states IDLE, ACTIVE and RECOVER.
REQ-019 In IDLE during FIGHT, a high kick request SHALL enter ACTIVE with kind=KICK, else a high punch request SHALL enter ACTIVE with kind=PUNCH; a request is ignored if block is also high.
REQ-020 ACTIVE SHALL last ACTIVE_FR frames, RECOVER SHALL last RECOVER_FR frames, then return to IDLE; requests outside IDLE SHALL be ignored (no queuing).
REQ-021 A hit SHALL be evaluated only on the first ACTIVE frame: gap = p2_left_edge - p1_right_edge, clamped to 0 when p2_left_edge <= p1_right_edge; hit lands if gap <= reach of the kind.
REQ-022 Damage SHALL be the kind's DMG, or DMG>>2 if the defender's block is high on the evaluation frame; health SHALL saturate at 0 (no wrap).
REQ-023 Hits by both players on the same frame SHALL both apply in that frame.
REQ-024 hit1/hit2 SHALL pulse for one frame, coincident with the frame hp is updated.
REQ-025 On leaving FIGHT, both sequencers SHALL force to IDLE within one frame; no damage SHALL apply outside FIGHT.

Reset
REQ-026 On Reset: game state START, sequencers IDLE, all counters 0, hp1=hp2=HP_MAX, hit1=hit2=0, deathL=deathR=0, startscreen=1; Reset mid-attack or mid-KO SHALL abort immediately.

Structure
REQ-027 Package fight_pkg SHALL hold game_state_t, atk_state_t, atk_kind_t and the default damage/reach/frame constants.
REQ-028 The per-player sequencer SHALL be sub-module attack_seq, instantiated twice; hit/damage arbitration and game FSM SHALL live in fight_ctrl.

Verification
REQ-029 Reset, start_key 0->1 -> FIGHT next frame, startscreen=0, hp1=hp2=100.
REQ-030 Edges 300/315, punch1 one frame -> hit2 pulse, hp2=95, atk1_busy high 16 frames; punch1 held throughout -> second attack only after IDLE.
REQ-031 Edges 300/360, kick1 -> no hit (gap 60>40); edges 300/330, kick1 with block2 high -> hp2 drops by 2.
REQ-032 Edges 300/310, punch1 and kick2 same frame -> hp2=95 and hp1=90 same frame, hit1 and hit2 both pulse.
REQ-033 hp2=5, kick1 landing -> hp2=0 (saturated), deathR=1, KO for 180 frames, then START; kick2 during KO -> hp1 unchanged.
